// File: rtl/alu_reservation_station_pkg.sv
// alu_reservation_station_pkg: shared backend types (opcodes, tag width, station entry)
package alu_reservation_station_pkg;
    localparam int TAG_W_DEF  = 6;
    localparam int RS_TAG_MAX = 16;
    localparam int RS_AGE_W   = 3;
    typedef enum logic [3:0] {
        ADD_I, SUB_I, AND_I, OR_I, XOR_I, SLL_I, SRL_I, SRA_I, SLT_I, ADDI_I, ANDI_I, ORI_I
    } instr_opcode;
    typedef struct packed {
        logic                  valid;
        instr_opcode           op;
        logic                  rdy1;
        logic                  rdy2;
        logic [RS_TAG_MAX-1:0] tag1;
        logic [RS_TAG_MAX-1:0] tag2;
        logic [31:0]           val1;
        logic [31:0]           val2;
        logic [31:0]           imm;
        logic [31:0]           pc;
        logic [RS_TAG_MAX-1:0] dst;
        logic [RS_AGE_W-1:0]   age;
    } rs_entry_t;
endpackage

// File: rtl/alu_reservation_station_age_select.sv
// rs_age_select: grants the eligible entry with the smallest age rank (ranks are unique)
module rs_age_select
    import alu_reservation_station_pkg::*;
#(
    parameter int N     = 4,
    parameter int AGE_W = RS_AGE_W
) (
    input  logic [N-1:0]            eligible,
    input  logic [N-1:0][AGE_W-1:0] age,
    output logic [N-1:0]            grant,
    output logic                    grant_valid
);
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < N; j++)
                if (j != i && eligible[j] && age[j] < age[i]) grant[i] = 1'b0;
        end
    end
    assign grant_valid = |eligible;
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: oldest-ready ALU reservation station with CDB wakeup.
// ALU_RS_CDB_BYPASS_EN lets an entry woken by the CDB issue in the same cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  instr_opcode      disp_opcode,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic [31:0]      disp_src1_val,
    input  logic [31:0]      disp_src2_val,
    input  logic [31:0]      disp_imm,
    input  logic [31:0]      disp_pc,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    output logic             iss_valid,
    input  logic             iss_ready,
    output instr_opcode      iss_opcode,
    output logic [31:0]      iss_val1,
    output logic [31:0]      iss_val2,
    output logic [31:0]      iss_imm,
    output logic [31:0]      iss_pc,
    output logic [TAG_W-1:0] iss_dst_tag
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    rs_entry_t ent [NUM_ENTRIES];
    rs_entry_t sel, dent, ient;
    logic [NUM_ENTRIES-1:0] vld, elig, grant, wake1, wake2;
    logic [NUM_ENTRIES-1:0][RS_AGE_W-1:0] age;
    logic [IDX_W-1:0] free_idx;
    logic [RS_AGE_W:0] cnt;
    logic [RS_TAG_MAX-1:0] ctag;
    logic grant_valid, disp_fire, load, issue_sel, direct;
    assign ctag = RS_TAG_MAX'(cdb_tag);
    always_comb begin
        vld = '0;
        elig = '0;
        wake1 = '0;
        wake2 = '0;
        age = '0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            vld[i] = ent[i].valid;
            age[i] = ent[i].age;
            wake1[i] = cdb_valid && ent[i].valid && !ent[i].rdy1 && ent[i].tag1 == ctag;
            wake2[i] = cdb_valid && ent[i].valid && !ent[i].rdy2 && ent[i].tag2 == ctag;
`ifdef ALU_RS_CDB_BYPASS_EN
            elig[i] = ent[i].valid && (ent[i].rdy1 || wake1[i]) && (ent[i].rdy2 || wake2[i]);
`else
            elig[i] = ent[i].valid && ent[i].rdy1 && ent[i].rdy2;
`endif
            if (!ent[i].valid) free_idx = IDX_W'(i);
        end
    end
    rs_age_select #(.N(NUM_ENTRIES), .AGE_W(RS_AGE_W)) u_sel (
        .eligible(elig), .age(age), .grant(grant), .grant_valid(grant_valid)
    );
    assign cnt        = (RS_AGE_W + 1)'($countones(vld));
    assign disp_ready = ~&vld;
    assign disp_fire  = disp_valid && disp_ready && !flush;
    assign load       = !iss_valid || iss_ready;
    assign issue_sel  = load && grant_valid;
    assign direct     = disp_fire && load && !grant_valid && dent.rdy1 && dent.rdy2;
    // A dispatching op captures a same-cycle broadcast; its rank counts survivors of this cycle's issue.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) if (grant[i]) sel = ent[i];
        dent = '0;
        dent.valid = 1'b1;
        dent.op = disp_opcode;
        dent.rdy1 = disp_src1_rdy || (cdb_valid && disp_src1_tag == cdb_tag);
        dent.rdy2 = disp_src2_rdy || (cdb_valid && disp_src2_tag == cdb_tag);
        dent.tag1 = RS_TAG_MAX'(disp_src1_tag);
        dent.tag2 = RS_TAG_MAX'(disp_src2_tag);
        dent.val1 = disp_src1_rdy ? disp_src1_val : cdb_val;
        dent.val2 = disp_src2_rdy ? disp_src2_val : cdb_val;
        dent.imm = disp_imm;
        dent.pc = disp_pc;
        dent.dst = RS_TAG_MAX'(disp_dst_tag);
        dent.age = RS_AGE_W'(cnt - (RS_AGE_W + 1)'(issue_sel));
        ient = grant_valid ? sel : dent;
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
            iss_valid <= 1'b0;
            iss_opcode <= ADD_I;
            iss_val1 <= '0;
            iss_val2 <= '0;
            iss_imm <= '0;
            iss_pc <= '0;
            iss_dst_tag <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wake1[i]) begin
                    ent[i].rdy1 <= 1'b1;
                    ent[i].val1 <= cdb_val;
                end
                if (wake2[i]) begin
                    ent[i].rdy2 <= 1'b1;
                    ent[i].val2 <= cdb_val;
                end
                if (issue_sel && grant[i]) ent[i].valid <= 1'b0;
                else if (issue_sel && ent[i].age > sel.age) ent[i].age <= ent[i].age - RS_AGE_W'(1);
            end
            if (disp_fire && !direct) ent[free_idx] <= dent;
            if (load) begin
                iss_valid <= grant_valid || direct;
                if (grant_valid || direct) begin
                    iss_opcode <= ient.op;
                    iss_val1 <= ient.rdy1 ? ient.val1 : cdb_val;
                    iss_val2 <= ient.rdy2 ? ient.val2 : cdb_val;
                    iss_imm <= ient.imm;
                    iss_pc <= ient.pc;
                    iss_dst_tag <= ient.dst[TAG_W-1:0];
                end
            end
        end
    end
endmodule

// File: doc/alu_reservation_station.md
ALU_RESERVATION_STATION -- requirements
Module: alu_reservation_station

Interface
REQ-001 Parameter: NUM_ENTRIES, 4, number of station entries (2..8).
REQ-002 Parameter: TAG_W, 6, physical register tag width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: flush  input  1  pipeline flush; discards all held work.
REQ-006 Ports (dispatch): disp_valid in 1; disp_ready out 1; disp_opcode in instr_opcode; disp_src1_rdy/disp_src2_rdy in 1; disp_src1_tag/disp_src2_tag in TAG_W; disp_src1_val/disp_src2_val in 32; disp_imm in 32, sign-extended; disp_pc in 32; disp_dst_tag in TAG_W.
REQ-007 Ports (wakeup bus): cdb_valid in 1; cdb_tag in TAG_W; cdb_val in 32, result broadcast.
REQ-008 Ports (issue to ALU): iss_valid out 1; iss_ready in 1; iss_opcode out instr_opcode; iss_val1/iss_val2/iss_imm/iss_pc out 32; iss_dst_tag out TAG_W.

Function
REQ-009 Dispatch transfer occurs when disp_valid && disp_ready && !flush; the op is written into the lowest-index free entry.
REQ-010 disp_ready SHALL be 1 iff at least one entry is free at the start of the cycle; an entry freed by issue in the same cycle is not reusable until the next cycle.
REQ-011 Each entry holds: valid, opcode, per-source ready/tag/value, imm, pc, dst_tag, and age rank.
REQ-012 On cdb_valid, every valid entry with a non-ready source whose tag equals cdb_tag SHALL latch cdb_val and set that source ready; both sources may wake on one broadcast.
REQ-013 A dispatching op whose non-ready source tag matches the same-cycle CDB broadcast SHALL be written with that source ready and value cdb_val.
REQ-014 An entry is eligible when valid with both sources ready; select picks the oldest eligible entry (dispatch order), ties impossible.
REQ-015 Output register: loads the selected entry when iss_valid == 0 or iss_ready == 1; the selected entry is deallocated in that same cycle.
REQ-016 iss_valid and iss_* SHALL hold stable while iss_valid && !iss_ready; latency dispatch-to-iss_valid is 1 cycle minimum (all sources ready at dispatch, station empty, output register free).
REQ-017 Throughput: one issue per cycle, one dispatch per cycle, concurrently.
REQ-018 Age ranks SHALL be renormalised on deallocation so that relative order of remaining entries is preserved; no wrap-around errors after unbounded operation.
REQ-019 flush SHALL invalidate all entries and the output register at the next edge; dispatch and CDB activity in the flush cycle are ignored; iss_valid is 0 in the cycle after flush.
REQ-020 Sources of immediate-form opcodes are marked ready by dispatch (disp_src2_rdy = 1); the station does not decode opcodes.

Reset
REQ-021 On rst all entries invalid, output register invalid; iss_valid = 0, disp_ready = 1 in the following cycle; iss_* data outputs = 0.
REQ-022 rst takes priority over flush, dispatch and CDB in the same cycle.

Configuration
REQ-023 Macro ALU_RS_CDB_BYPASS_EN defined: an entry woken by the CDB in cycle N is eligible for select in cycle N, with operand taken directly from cdb_val.
REQ-024 Macro ALU_RS_CDB_BYPASS_EN undefined: an entry woken in cycle N is eligible in cycle N+1 at the earliest; REQ-013 capture still applies.

Structure
REQ-025 instr_opcode, TAG_W default and the entry struct typedef SHALL reside in the shared backend package.
REQ-026 Oldest-ready selection SHALL be a sub-module rs_age_select (inputs: eligible vector, age ranks; outputs: one-hot grant, grant_valid).

Verification
REQ-027 After reset, dispatch ADD_I with src1=5, src2=7 both ready -> next cycle iss_valid=1, iss_val1=5, iss_val2=7, iss_dst_tag as dispatched.
REQ-028 Dispatch SUB_I src1 tag 9 not ready, then cdb_valid tag 9 val 0x20 -> issue one cycle later without bypass (same cycle with ALU_RS_CDB_BYPASS_EN), iss_val1=0x20.
REQ-029 Fill 4 entries all waiting on tag 3 -> disp_ready=0; broadcast tag 3 -> four issues in dispatch order on consecutive cycles; disp_ready=1 cycle after first issue.
REQ-030 Hold iss_ready=0 for 3 cycles with iss_valid=1 -> iss_* unchanged; no entry deallocated beyond the held op.
REQ-031 Station holding 3 entries plus output register valid, assert flush with concurrent disp_valid -> next cycle iss_valid=0, disp_ready=1, dropped op never issues.
